// File: rtl/track_playback_scheduler.sv
// rtl/track_playback_scheduler.sv - queued track index to flash address sequencer feeding AC97 samples
// Optional underrun counter port enabled by defining TRACK_SCHED_UNDERRUN_EN.
`timescale 1ns/1ps
module track_playback_scheduler #(
    parameter int TRACK_LENGTH = 69000,
    parameter int ADDR_W       = 23,
    parameter int IDX_W        = 5,
    parameter int QUEUE_DEPTH  = 4,
    parameter int SKIP_INDEX   = 28,
    parameter int UNUSED_INDEX = 31
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enq_valid,
    input  logic [IDX_W-1:0]  enq_index,
    output logic              enq_ready,
    input  logic              start,
    input  logic              abort,
    input  logic              ready,
    input  logic              fm_busy,
    input  logic [15:0]       frdata,
    output logic [ADDR_W-1:0] raddr,
    output logic              doread,
    output logic [7:0]        to_ac97_data,
    output logic              playing,
    output logic [IDX_W-1:0]  cur_index,
    output logic [2:0]        queue_count,
    output logic              done
`ifdef TRACK_SCHED_UNDERRUN_EN
    ,
    output logic [7:0]        underrun_count
`endif
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [2:0]        DEPTH_C   = 3'(QUEUE_DEPTH);
    localparam logic [ADDR_W-1:0] TRACK_LEN = ADDR_W'(TRACK_LENGTH);
    localparam logic [IDX_W-1:0]  SKIP_I    = IDX_W'(SKIP_INDEX);
    localparam logic [IDX_W-1:0]  UNUSED_I  = IDX_W'(UNUSED_INDEX);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SETUP, S_PLAY, S_DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  q_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [IDX_W-1:0]  head;
    logic              push;
    logic              pop;
    logic              ready_q;
    logic              start_q;
    logic              ready_rise;
    logic              start_rise;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] end_addr;
    logic              unused_low;

    assign unused_low = ^frdata[7:0];
    assign enq_ready  = (queue_count != DEPTH_C);
    assign head       = q_mem[rd_ptr];
    // abort wins over a same-cycle push or pop
    assign push       = enq_valid && enq_ready && !abort;
    assign pop        = (state == S_FETCH) && (queue_count != 3'd0) && !abort;
    assign ready_rise = ready && !ready_q;
    assign start_rise = start && !start_q;

    always_ff @(posedge clock) begin
        if (push) begin
            q_mem[wr_ptr] <= enq_index;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= 3'd0;
        end else if (abort) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   queue_count <= queue_count + 3'd1;
                2'b01:   queue_count <= queue_count - 3'd1;
                default: queue_count <= queue_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            ready_q      <= 1'b0;
            start_q      <= 1'b0;
            raddr        <= '0;
            end_addr     <= '0;
            base         <= '0;
            doread       <= 1'b0;
            to_ac97_data <= 8'd0;
            playing      <= 1'b0;
            cur_index    <= UNUSED_I;
            done         <= 1'b0;
`ifdef TRACK_SCHED_UNDERRUN_EN
            underrun_count <= 8'd0;
`endif
        end else begin
            ready_q <= ready;
            start_q <= start;
            done    <= 1'b0;
            if (abort) begin
                state        <= S_IDLE;
                raddr        <= '0;
                doread       <= 1'b0;
                to_ac97_data <= 8'd0;
                playing      <= 1'b0;
`ifdef TRACK_SCHED_UNDERRUN_EN
                underrun_count <= 8'd0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_rise) begin
                            if (queue_count != 3'd0) state <= S_FETCH;
                            else                     done  <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        if (queue_count == 3'd0) begin
                            state <= S_DONE;
                        end else if (head == SKIP_I) begin
                            state <= S_FETCH;
                        end else if (head > SKIP_I) begin
                            state <= S_DONE;
                        end else begin
                            cur_index <= head;
                            base      <= ADDR_W'(head) * TRACK_LEN;
                            playing   <= 1'b1;
                            state     <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        raddr    <= base;
                        end_addr <= base + TRACK_LEN;
                        doread   <= 1'b1;
                        state    <= S_PLAY;
                    end
                    S_PLAY: begin
                        // a busy flash at the strobe holds the last sample rather than reading stale data
                        if (ready_rise) begin
                            if (fm_busy) begin
`ifdef TRACK_SCHED_UNDERRUN_EN
                                if (underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
`endif
                            end else if (raddr < end_addr) begin
                                to_ac97_data <= frdata[15:8];
                                raddr        <= raddr + 1'b1;
                            end else begin
                                playing <= 1'b0;
                                state   <= S_FETCH;
                            end
                        end
                    end
                    S_DONE: begin
                        done         <= 1'b1;
                        doread       <= 1'b0;
                        raddr        <= '0;
                        to_ac97_data <= 8'd0;
                        state        <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_track_playback_scheduler.sv
// tb/tb_track_playback_scheduler.sv - self-checking bench for track_playback_scheduler
`timescale 1ns/1ps
module tb_track_playback_scheduler;

    localparam int TL   = 69000;
    localparam int S_TL = 16;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic        enq_valid, enq_ready, start, abort, ready, fm_busy, doread, playing, done;
    logic [4:0]  enq_index, cur_index;
    logic [15:0] frdata;
    logic [22:0] raddr;
    logic [7:0]  to_ac97_data;
    logic [2:0]  queue_count;

    logic        s_enq_valid, s_enq_ready, s_start, s_abort, s_ready, s_fm_busy, s_doread, s_playing, s_done;
    logic [4:0]  s_enq_index, s_cur_index;
    logic [15:0] s_frdata;
    logic [22:0] s_raddr;
    logic [7:0]  s_to_ac97_data;
    logic [2:0]  s_queue_count;
`ifdef TRACK_SCHED_UNDERRUN_EN
    logic [7:0]  underrun_count, s_underrun_count;
`endif

    logic [15:0] salt;
    int passed = 0;
    int total  = 0;
    int done_seen = 0, s_done_seen = 0, bad_read = 0, play_seen = 0;

    function automatic logic [15:0] flash_word(input logic [22:0] a, input logic [15:0] s);
        logic [31:0] t;
        t = 32'(a) * 32'd40503 + 32'(s);
        return t[23:8];
    endfunction

    function automatic logic [7:0] sample_at(input int a);
        logic [15:0] w;
        w = flash_word(23'(a), salt);
        return w[15:8];
    endfunction

    assign frdata   = flash_word(raddr, salt);
    assign s_frdata = flash_word(s_raddr, salt);

    track_playback_scheduler dut (
        .clock(clock), .reset_n(reset_n), .enq_valid(enq_valid), .enq_index(enq_index),
        .enq_ready(enq_ready), .start(start), .abort(abort), .ready(ready), .fm_busy(fm_busy),
        .frdata(frdata), .raddr(raddr), .doread(doread), .to_ac97_data(to_ac97_data),
        .playing(playing), .cur_index(cur_index), .queue_count(queue_count), .done(done)
`ifdef TRACK_SCHED_UNDERRUN_EN
        , .underrun_count(underrun_count)
`endif
    );

    track_playback_scheduler #(.TRACK_LENGTH(S_TL)) dut_s (
        .clock(clock), .reset_n(reset_n), .enq_valid(s_enq_valid), .enq_index(s_enq_index),
        .enq_ready(s_enq_ready), .start(s_start), .abort(s_abort), .ready(s_ready), .fm_busy(s_fm_busy),
        .frdata(s_frdata), .raddr(s_raddr), .doread(s_doread), .to_ac97_data(s_to_ac97_data),
        .playing(s_playing), .cur_index(s_cur_index), .queue_count(s_queue_count), .done(s_done)
`ifdef TRACK_SCHED_UNDERRUN_EN
        , .underrun_count(s_underrun_count)
`endif
    );

    always @(posedge clock) begin
        if (done) done_seen <= done_seen + 1;
        if (s_done) s_done_seen <= s_done_seen + 1;
        if (doread && raddr != 23'd0) bad_read <= bad_read + 1;
        if (playing) play_seen <= play_seen + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic edge_m(input logic busy);
        ready = 1'b1; fm_busy = busy; tick();
        ready = 1'b0; fm_busy = 1'b0; tick();
    endtask

    task automatic edge_s(input logic busy);
        s_ready = 1'b1; s_fm_busy = busy; tick();
        s_ready = 1'b0; s_fm_busy = 1'b0; tick();
    endtask

    task automatic push_m(input logic [4:0] i);
        enq_valid = 1'b1; enq_index = i; tick(); enq_valid = 1'b0;
    endtask

    task automatic push_s(input logic [4:0] i);
        s_enq_valid = 1'b1; s_enq_index = i; tick(); s_enq_valid = 1'b0;
    endtask

    task automatic start_m();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic start_s();
        s_start = 1'b1; tick(); s_start = 1'b0;
    endtask

    task automatic test_reset();
        {enq_valid, start, abort, ready, fm_busy} = '0; enq_index = '0;
        {s_enq_valid, s_start, s_abort, s_ready, s_fm_busy} = '0; s_enq_index = '0;
        salt = 16'($urandom);
        reset_n = 1'b0; tick(); tick(); reset_n = 1'b1; tick();
        total++; if (raddr !== 23'd0) $display("FAIL reset_raddr got %0d want 0", raddr); else passed++;
        total++; if (doread !== 1'b0) $display("FAIL reset_doread got %b want 0", doread); else passed++;
        total++; if (to_ac97_data !== 8'd0) $display("FAIL reset_data got %0d want 0", to_ac97_data); else passed++;
        total++; if (playing !== 1'b0) $display("FAIL reset_playing got %b want 0", playing); else passed++;
        total++; if (cur_index !== 5'd31) $display("FAIL reset_cur_index got %0d want 31", cur_index); else passed++;
        total++; if (queue_count !== 3'd0) $display("FAIL reset_count got %0d want 0", queue_count); else passed++;
        total++; if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready got %b want 1", enq_ready); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    endtask

    task automatic test_empty_start();
        int d0;
        d0 = done_seen;
        start_m(); repeat (3) tick();
        total++; if (done_seen - d0 !== 1) $display("FAIL empty_start_done got %0d pulses want 1", done_seen - d0); else passed++;
        total++; if (playing !== 1'b0) $display("FAIL empty_start_playing got %b want 0", playing); else passed++;
    endtask

    task automatic test_first_track();
        push_m(5'd3); push_m(5'd26); push_m(5'd25); push_m(5'd31);
        total++; if (queue_count !== 3'd4 || enq_ready !== 1'b0) $display("FAIL first_fill got count=%0d ready=%b want 4/0", queue_count, enq_ready); else passed++;
        start_m(); tick(); tick();
        total++; if (raddr !== 23'(3 * TL)) $display("FAIL first_base got %0d want %0d", raddr, 3 * TL); else passed++;
        total++; if (cur_index !== 5'd3 || doread !== 1'b1 || playing !== 1'b1) $display("FAIL first_setup got idx=%0d doread=%b playing=%b want 3/1/1", cur_index, doread, playing); else passed++;
        total++; if (queue_count !== 3'd3) $display("FAIL first_count got %0d want 3", queue_count); else passed++;
        for (int k = 0; k < 5; k++) begin
            edge_m(1'b0);
            total++; if (to_ac97_data !== sample_at(3 * TL + k)) $display("FAIL first_sample%0d got %0h want %0h", k, to_ac97_data, sample_at(3 * TL + k)); else passed++;
            total++; if (raddr !== 23'(3 * TL + k + 1)) $display("FAIL first_addr%0d got %0d want %0d", k, raddr, 3 * TL + k + 1); else passed++;
        end
    endtask

    task automatic test_busy_hold();
        repeat (3) edge_m(1'b1);
        total++; if (raddr !== 23'(3 * TL + 5)) $display("FAIL busy_addr got %0d want %0d", raddr, 3 * TL + 5); else passed++;
        total++; if (to_ac97_data !== sample_at(3 * TL + 4)) $display("FAIL busy_sample got %0h want %0h", to_ac97_data, sample_at(3 * TL + 4)); else passed++;
`ifdef TRACK_SCHED_UNDERRUN_EN
        total++; if (underrun_count !== 8'd3) $display("FAIL busy_underrun got %0d want 3", underrun_count); else passed++;
`endif
        edge_m(1'b0);
        total++; if (to_ac97_data !== sample_at(3 * TL + 5) || raddr !== 23'(3 * TL + 6)) $display("FAIL busy_resume got %0h/%0d want %0h/%0d", to_ac97_data, raddr, sample_at(3 * TL + 5), 3 * TL + 6); else passed++;
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_seen;
        abort = 1'b1; enq_valid = 1'b1; enq_index = 5'd7; tick(); abort = 1'b0; enq_valid = 1'b0;
        total++; if (playing !== 1'b0 || doread !== 1'b0) $display("FAIL abort_stop got playing=%b doread=%b want 0/0", playing, doread); else passed++;
        total++; if (to_ac97_data !== 8'd0) $display("FAIL abort_mute got %0h want 0", to_ac97_data); else passed++;
        total++; if (queue_count !== 3'd0) $display("FAIL abort_flush got %0d want 0", queue_count); else passed++;
        repeat (4) tick();
        total++; if (done_seen !== d0) $display("FAIL abort_no_done got %0d pulses want 0", done_seen - d0); else passed++;
`ifdef TRACK_SCHED_UNDERRUN_EN
        total++; if (underrun_count !== 8'd0) $display("FAIL abort_underrun got %0d want 0", underrun_count); else passed++;
`endif
    endtask

    task automatic test_queue_full();
        push_m(5'd28); push_m(5'd28); push_m(5'd5); push_m(5'd6);
        total++; if (queue_count !== 3'd4 || enq_ready !== 1'b0) $display("FAIL full_count got %0d/%b want 4/0", queue_count, enq_ready); else passed++;
        push_m(5'd7);
        total++; if (queue_count !== 3'd4) $display("FAIL full_drop got %0d want 4", queue_count); else passed++;
        start_m();
        tick();
        total++; if (queue_count !== 3'd3) $display("FAIL fetch_pop got %0d want 3", queue_count); else passed++;
        enq_valid = 1'b1; enq_index = 5'd9; tick(); enq_valid = 1'b0;
        total++; if (queue_count !== 3'd3) $display("FAIL push_pop got %0d want 3", queue_count); else passed++;
        tick();
        total++; if (queue_count !== 3'd2 || cur_index !== 5'd5) $display("FAIL full_setup got count=%0d idx=%0d want 2/5", queue_count, cur_index); else passed++;
        tick();
        total++; if (raddr !== 23'(5 * TL)) $display("FAIL full_base got %0d want %0d", raddr, 5 * TL); else passed++;
        abort = 1'b1; tick(); abort = 1'b0; tick();
    endtask

    task automatic test_terminator();
        int d0, b0, p0;
        d0 = done_seen; b0 = bad_read; p0 = play_seen;
        push_m(5'd30); start_m(); repeat (6) tick();
        total++; if (done_seen - d0 !== 1) $display("FAIL term_done got %0d pulses want 1", done_seen - d0); else passed++;
        total++; if (bad_read !== b0 || play_seen !== p0) $display("FAIL term_no_play got reads=%0d plays=%0d want 0/0", bad_read - b0, play_seen - p0); else passed++;
        total++; if (raddr !== 23'd0 || queue_count !== 3'd0) $display("FAIL term_state got %0d/%0d want 0/0", raddr, queue_count); else passed++;
    endtask

    task automatic test_reset_midplay();
        push_m(5'd4); push_m(5'd9); start_m(); tick(); tick();
        edge_m(1'b0); edge_m(1'b0);
        total++; if (raddr !== 23'(4 * TL + 2)) $display("FAIL midplay_addr got %0d want %0d", raddr, 4 * TL + 2); else passed++;
        #2 reset_n = 1'b0; #1;
        total++; if (raddr !== 23'd0 || playing !== 1'b0 || doread !== 1'b0) $display("FAIL async_reset got %0d/%b/%b want 0/0/0", raddr, playing, doread); else passed++;
        total++; if (queue_count !== 3'd0 || cur_index !== 5'd31 || to_ac97_data !== 8'd0) $display("FAIL async_reset_q got %0d/%0d/%0h want 0/31/0", queue_count, cur_index, to_ac97_data); else passed++;
        tick(); reset_n = 1'b1; tick();
    endtask

    task automatic test_full_track();
        int d0;
        d0 = s_done_seen;
        push_s(5'd28); push_s(5'd16); start_s(); repeat (3) tick();
        total++; if (s_raddr !== 23'(16 * S_TL) || s_cur_index !== 5'd16) $display("FAIL skip_base got %0d/%0d want %0d/16", s_raddr, s_cur_index, 16 * S_TL); else passed++;
        total++; if (s_queue_count !== 3'd0) $display("FAIL skip_count got %0d want 0", s_queue_count); else passed++;
        for (int k = 0; k < S_TL; k++) begin
            edge_s(1'b0);
            total++; if (s_to_ac97_data !== sample_at(16 * S_TL + k) || s_raddr !== 23'(16 * S_TL + k + 1)) $display("FAIL full_sample%0d got %0h/%0d want %0h/%0d", k, s_to_ac97_data, s_raddr, sample_at(16 * S_TL + k), 16 * S_TL + k + 1); else passed++;
        end
        edge_s(1'b0); repeat (4) tick();
        total++; if (s_done_seen - d0 !== 1) $display("FAIL full_done got %0d pulses want 1", s_done_seen - d0); else passed++;
        total++; if (s_raddr !== 23'd0 || s_doread !== 1'b0 || s_to_ac97_data !== 8'd0) $display("FAIL full_end got %0d/%b/%0h want 0/0/0", s_raddr, s_doread, s_to_ac97_data); else passed++;
    endtask

    task automatic test_random_sequences();
        for (int it = 0; it < 6; it++) begin
            int n, consumed, d0, a;
            bit stopped;
            logic [4:0] entries [4];
            int tracks[$];
            logic [7:0] exp_data;
            n = $urandom_range(1, 4); consumed = 0; stopped = 0; exp_data = 8'd0;
            for (int e = 0; e < n; e++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 7)      entries[e] = 5'($urandom_range(0, 27));
                else if (r < 9) entries[e] = 5'd28;
                else            entries[e] = 5'($urandom_range(29, 31));
                if (!stopped) begin
                    consumed++;
                    if (entries[e] > 5'd28) stopped = 1;
                    else if (entries[e] != 5'd28) tracks.push_back(int'(entries[e]));
                end
                push_s(entries[e]);
            end
            d0 = s_done_seen;
            start_s();
            foreach (tracks[t]) begin
                for (int w = 0; w < 12 && !s_playing; w++) tick();
                total++; if (!s_playing) $display("FAIL rnd_wait_play it%0d got no playing want track %0d", it, tracks[t]); else passed++;
                tick();
                a = tracks[t] * S_TL;
                total++; if (s_raddr !== 23'(a) || s_cur_index !== 5'(tracks[t])) $display("FAIL rnd_base it%0d got %0d/%0d want %0d/%0d", it, s_raddr, s_cur_index, a, tracks[t]); else passed++;
                for (int produced = 0; produced < S_TL; ) begin
                    logic busy;
                    busy = ($urandom_range(0, 3) == 0);
                    edge_s(busy);
                    if (!busy) begin
                        exp_data = sample_at(a); a++; produced++;
                    end
                    total++; if (s_raddr !== 23'(a) || s_to_ac97_data !== exp_data) $display("FAIL rnd_edge it%0d busy=%b got %0d/%0h want %0d/%0h", it, busy, s_raddr, s_to_ac97_data, a, exp_data); else passed++;
                end
                edge_s(1'b0);
            end
            for (int w = 0; w < 12 && s_done_seen == d0; w++) tick();
            tick(); tick();
            total++; if (s_done_seen - d0 !== 1) $display("FAIL rnd_done it%0d got %0d pulses want 1", it, s_done_seen - d0); else passed++;
            total++; if (s_raddr !== 23'd0 || s_queue_count !== 3'(n - consumed)) $display("FAIL rnd_end it%0d got %0d/%0d want 0/%0d", it, s_raddr, s_queue_count, n - consumed); else passed++;
            s_abort = 1'b1; tick(); s_abort = 1'b0; tick();
        end
    endtask

    initial begin
        test_reset();
        test_empty_start();
        test_first_track();
        test_busy_hold();
        test_abort();
        test_queue_full();
        test_terminator();
        test_reset_midplay();
        test_full_track();
        test_random_sequences();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
